// File: rtl/dram_pkg.sv
// dram_pkg: shared DRAM command/row-status types, default timings and row width
package dram_pkg;

    localparam int ROW_BITS    = 16;
    localparam int T_RP_DFLT   = 4;
    localparam int T_RCD_DFLT  = 4;
    localparam int T_RFC_DFLT  = 16;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_PRE, CMD_PREA, CMD_RD, CMD_WR, CMD_REF
    } dram_cmd_t;

    typedef enum logic [1:0] {
        ROW_IDLE, ROW_HIT, ROW_MISS, ROW_CONFLICT
    } row_stat_t;

endpackage

// File: rtl/row_cmd_sequencer.sv
// row_cmd_sequencer: turns one RD/WR request into the PRE/ACT/RD/WR command sequence and services refresh
//   CLK, nRST              clock, asynchronous active-low reset
//   req_*                  request handshake, direction and address
//   ref_req / ref_ack      refresh request level / completion pulse
//   ro_*                   row-tracker lookup address, strobes and status
//   cmd_valid, cmd, cmd_*  issued DRAM command and its address
//   done                   pulses with the RD/WR issue
//   hit_cnt, miss_cnt, conflict_cnt  saturating lookup statistics, present only with ROW_CMD_SEQ_PERF_CNT_EN
module row_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int T_RP  = T_RP_DFLT,
    parameter int T_RCD = T_RCD_DFLT,
    parameter int T_RFC = T_RFC_DFLT
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_bg,
    input  logic [1:0]          req_bank,
    input  logic [ROW_BITS-1:0] req_row,
    input  logic                ref_req,
    output logic                ref_ack,
    output logic                ro_req_en,
    output logic                ro_refresh,
    output logic                ro_row_resolve,
    output logic                ro_tACT_done,
    output logic [1:0]          ro_bank_group,
    output logic [1:0]          ro_bank,
    output logic [ROW_BITS-1:0] ro_row,
    input  logic [1:0]          ro_row_stat,
    input  logic [ROW_BITS-1:0] ro_row_conflict,
    input  logic                ro_all_row_closed,
    output logic                cmd_valid,
    output logic [2:0]          cmd,
    output logic [1:0]          cmd_bg,
    output logic [1:0]          cmd_bank,
    output logic [ROW_BITS-1:0] cmd_row,
`ifdef ROW_CMD_SEQ_PERF_CNT_EN
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    output logic [31:0]         conflict_cnt,
`endif
    output logic                done
);

    // The ACT-to-column wait spans T_RCD cycles so ACT and the column command
    // sit T_RCD+1 cycles apart, giving the 3+T_RCD miss latency. A zero-length
    // wait is skipped entirely.
    localparam int RP_WAIT  = T_RP - 1;
    localparam int RCD_WAIT = T_RCD;
    localparam int RFC_WAIT = T_RFC - 1;
    localparam int CNT_MAX  = (T_RP > T_RCD) ? ((T_RP > T_RFC) ? T_RP : T_RFC)
                                             : ((T_RCD > T_RFC) ? T_RCD : T_RFC);
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD,
        S_COL, S_PREA, S_WAIT_PA, S_REF, S_WAIT_RFC
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [1:0]          bg_q, bank_q;
    logic [ROW_BITS-1:0] row_q, conf_row_q;
    logic                write_q;
    logic                last;
    row_stat_t           stat;
    dram_cmd_t           cmd_e;

    assign stat = row_stat_t'(ro_row_stat);
    assign last = cnt == CNT_W'(1);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     state_n = ref_req ? (ro_all_row_closed ? S_REF : S_PREA)
                                          : (req_valid ? S_LOOKUP : S_IDLE);
            S_LOOKUP:   state_n = stat == ROW_HIT      ? S_COL :
                                  stat == ROW_CONFLICT ? S_PRE : S_ACT;
            S_PRE:      state_n = RP_WAIT > 0 ? S_WAIT_RP : S_ACT;
            S_WAIT_RP:  state_n = last ? S_ACT : S_WAIT_RP;
            S_ACT:      state_n = RCD_WAIT > 0 ? S_WAIT_RCD : S_COL;
            S_WAIT_RCD: state_n = last ? S_COL : S_WAIT_RCD;
            S_COL:      state_n = S_IDLE;
            S_PREA:     state_n = RP_WAIT > 0 ? S_WAIT_PA : S_REF;
            S_WAIT_PA:  state_n = last ? S_REF : S_WAIT_PA;
            S_REF:      state_n = RFC_WAIT > 0 ? S_WAIT_RFC : S_IDLE;
            S_WAIT_RFC: state_n = last ? S_IDLE : S_WAIT_RFC;
            default:    state_n = S_IDLE;
        endcase
    end

    // The counter loads on every state change and only runs down inside wait states.
    always_comb begin
        cnt_n = cnt > CNT_W'(1) ? cnt - CNT_W'(1) : cnt;
        if (state_n != state)
            cnt_n = state_n inside {S_WAIT_RP, S_WAIT_PA} ? CNT_W'(RP_WAIT)  :
                    state_n == S_WAIT_RCD                 ? CNT_W'(RCD_WAIT) :
                    state_n == S_WAIT_RFC                 ? CNT_W'(RFC_WAIT) : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bg_q       <= '0;
            bank_q     <= '0;
            row_q      <= '0;
            conf_row_q <= '0;
            write_q    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (req_ready && req_valid) begin
                bg_q    <= req_bg;
                bank_q  <= req_bank;
                row_q   <= req_row;
                write_q <= req_write;
            end
            if (state == S_LOOKUP)
                conf_row_q <= ro_row_conflict;
        end
    end

`ifdef ROW_CMD_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            conflict_cnt <= '0;
        end else if (state == S_LOOKUP) begin
            if (stat == ROW_HIT && !(&hit_cnt))
                hit_cnt <= hit_cnt + 32'd1;
            if (stat == ROW_MISS && !(&miss_cnt))
                miss_cnt <= miss_cnt + 32'd1;
            if (stat == ROW_CONFLICT && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

    assign cmd_e = state == S_PRE  ? CMD_PRE  :
                   state == S_ACT  ? CMD_ACT  :
                   state == S_COL  ? (write_q ? CMD_WR : CMD_RD) :
                   state == S_PREA ? CMD_PREA :
                   state == S_REF  ? CMD_REF  : CMD_NOP;

    assign req_ready      = nRST && state == S_IDLE && !ref_req;
    assign cmd            = cmd_e;
    assign cmd_valid      = cmd_e != CMD_NOP;
    assign cmd_bg         = bg_q;
    assign cmd_bank       = bank_q;
    assign cmd_row        = state == S_PRE ? conf_row_q : row_q;
    assign ro_bank_group  = bg_q;
    assign ro_bank        = bank_q;
    assign ro_row         = row_q;
    assign ro_req_en      = state == S_LOOKUP;
    assign ro_row_resolve = state == S_PRE;
    assign ro_tACT_done   = (state == S_WAIT_RCD && last) || (state == S_ACT && RCD_WAIT == 0);
    assign ro_refresh     = state inside {S_PREA, S_WAIT_PA, S_REF, S_WAIT_RFC};
    assign ref_ack        = (state == S_WAIT_RFC && last) || (state == S_REF && RFC_WAIT == 0);
    assign done           = state == S_COL;

endmodule

// File: tb/tb_row_cmd_sequencer.sv
// tb_row_cmd_sequencer: randomized and directed checks of row_cmd_sequencer against a latency-formula model
module tb_row_cmd_sequencer;
    import dram_pkg::*;

    localparam int T_RP  = 4;
    localparam int T_RCD = 4;
    localparam int T_RFC = 16;

    logic                CLK = 1'b0;
    logic                nRST = 1'b0;
    logic                req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [1:0]          req_bg = '0, req_bank = '0;
    logic [ROW_BITS-1:0] req_row = '0;
    logic                ref_req = 1'b0, ref_ack;
    logic                ro_req_en, ro_refresh, ro_row_resolve, ro_tACT_done;
    logic [1:0]          ro_bank_group, ro_bank;
    logic [ROW_BITS-1:0] ro_row;
    logic [1:0]          ro_row_stat = '0;
    logic [ROW_BITS-1:0] ro_row_conflict = '0;
    logic                ro_all_row_closed = 1'b1;
    logic                cmd_valid;
    logic [2:0]          cmd;
    logic [1:0]          cmd_bg, cmd_bank;
    logic [ROW_BITS-1:0] cmd_row;
    logic                done;

    int tests = 0;
    int fails = 0;

    row_cmd_sequencer #(.T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .ro_req_en(ro_req_en), .ro_refresh(ro_refresh), .ro_row_resolve(ro_row_resolve),
        .ro_tACT_done(ro_tACT_done), .ro_bank_group(ro_bank_group), .ro_bank(ro_bank),
        .ro_row(ro_row), .ro_row_stat(ro_row_stat), .ro_row_conflict(ro_row_conflict),
        .ro_all_row_closed(ro_all_row_closed),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Accept-to-column latency straight from the latency rules.
    function automatic int col_lat(input int stat);
        return stat == 1 ? 2 : stat == 3 ? 3 + T_RP + T_RCD : 3 + T_RCD;
    endfunction

    // Expected {cmd_valid, cmd, done, ro_req_en, ro_tACT_done, ro_row_resolve} k cycles after accept.
    function automatic logic [7:0] req_vec(input int k, input int stat, input bit w);
        int pre_at, act_at, col_at;
        dram_cmd_t e;
        col_at = col_lat(stat);
        pre_at = stat == 3 ? 2 : -1;
        act_at = stat == 3 ? 2 + T_RP : stat == 1 ? -1 : 2;
        e = k == pre_at ? CMD_PRE : k == act_at ? CMD_ACT :
            k == col_at ? (w ? CMD_WR : CMD_RD) : CMD_NOP;
        return {e != CMD_NOP, e, k == col_at, k == 1, act_at >= 0 && k == col_at - 1, k == pre_at};
    endfunction

    // Runs from the negedge of an IDLE cycle with ref_req high; ends on the negedge
    // of the first IDLE cycle after the refresh with ref_req dropped.
    task automatic ref_trace(input bit closed);
        int ref_at, ack_at;
        dram_cmd_t e;
        ref_at = closed ? 1 : 1 + T_RP;
        ack_at = ref_at + T_RFC - 1;
        for (int k = 1; k <= ack_at; k++) begin
            @(negedge CLK);
            e = (k == 1 && !closed) ? CMD_PREA : k == ref_at ? CMD_REF : CMD_NOP;
            check($sformatf("ref_k%0d", k), {cmd_valid, cmd, ro_refresh, ref_ack, req_ready},
                  {e != CMD_NOP, e, 1'b1, k == ack_at, 1'b0});
            if (k == ack_at) ref_req = 1'b0;
        end
        @(negedge CLK);
        check("ref_end", {ro_refresh, req_ready, cmd_valid}, 3'b010);
    endtask

    // Called on a negedge; drives one request and checks every cycle up to the column command.
    task automatic do_req(input int stat, input bit w, input logic [1:0] bg, input logic [1:0] bank,
                          input logic [ROW_BITS-1:0] row, input logic [ROW_BITS-1:0] crow,
                          input bit ref_mid, input bit closed);
        int n, lat;
        logic [7:0] v;
        lat = col_lat(stat);
        req_valid = 1'b1; req_write = w; req_bg = bg; req_bank = bank; req_row = row;
        ro_row_stat = 2'(stat); ro_row_conflict = crow; ro_all_row_closed = closed;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("accept", req_ready, 1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLK);
            v = req_vec(k, stat, w);
            check($sformatf("req_s%0d_k%0d", stat, k), {cmd_valid, cmd, done, ro_req_en, ro_tACT_done, ro_row_resolve}, v);
            if (k == 1)
                check("ro_addr", {ro_bank_group, ro_bank, ro_row}, {bg, bank, row});
            if (v[6:4] == 3'(CMD_PRE))
                check("pre_row", {cmd_bg, cmd_bank, cmd_row}, {bg, bank, crow});
            else if (v[7])
                check("cmd_addr", {cmd_bg, cmd_bank, cmd_row}, {bg, bank, row});
            if (ref_mid && k == lat - 1) ref_req = 1'b1;
        end
        @(negedge CLK);
        check("post_req", {req_ready, cmd_valid, ro_refresh}, {!ref_mid, 2'b00});
        if (ref_mid) ref_trace(closed);
    endtask

    initial begin
        #1;
        check("rst_outs", {req_ready, cmd_valid, cmd, done, ref_ack, ro_req_en, ro_refresh, ro_row_resolve, ro_tACT_done},
              12'h000);
        check("rst_addr", {ro_bank_group, ro_bank, ro_row, cmd_row}, '0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("idle_ready", req_ready, 1);

        do_req(1, 1'b0, 2'd1, 2'd2, 16'h01A3, 16'h0, 1'b0, 1'b1);
        do_req(2, 1'b1, 2'd3, 2'd0, 16'h0BEE, 16'h0, 1'b0, 1'b1);
        do_req(3, 1'b0, 2'd2, 2'd1, 16'h0123, 16'h0055, 1'b0, 1'b1);

        // Refresh and request raised together with banks open.
        ro_all_row_closed = 1'b0;
        ref_req = 1'b1;
        req_valid = 1'b1;
        #1 check("simul_ready", req_ready, 0);
        ref_trace(1'b0);
        do_req(0, 1'b1, 2'd0, 2'd3, 16'h7001, 16'h0, 1'b0, 1'b0);

        // Refresh raised while a miss sits in WAIT_RCD.
        do_req(2, 1'b0, 2'd1, 2'd1, 16'h4242, 16'h0, 1'b1, 1'b0);

        // Reset during WAIT_RP of a conflict.
        req_valid = 1'b1; req_write = 1'b0; req_bg = 2'd2; req_bank = 2'd2; req_row = 16'h3333;
        ro_row_stat = 2'd3; ro_row_conflict = 16'h0999;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge CLK);
        check("pre_rst_k4", {cmd_valid, cmd}, 4'h0);
        nRST = 1'b0;
        #1;
        check("rst_mid_outs", {req_ready, cmd_valid, cmd, done, ref_ack, ro_req_en, ro_refresh, ro_row_resolve, ro_tACT_done},
              12'h000);
        check("rst_mid_addr", {ro_bank_group, ro_bank, ro_row, cmd_row}, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("rst_hold", {cmd_valid, done}, 2'b00);
        end
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rst_release", {req_ready, cmd_valid}, 2'b10);
        end

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                ro_all_row_closed = 1'($urandom);
                ref_req = 1'b1;
                #1 check("rnd_ref_ready", req_ready, 0);
                ref_trace(ro_all_row_closed);
            end else begin
                do_req(int'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 2'($urandom),
                       16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1);
    end

endmodule
